// File: rtl/router_pkg.sv
// router_pkg: shared widths and header field constants for the router datapath.
package router_pkg;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: running XOR parity, received parity capture and mismatch flag.
module router_parity_acc
  import router_pkg::*;
#(
  parameter int DW = router_pkg::DW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          xor_en,
  input  logic [DW-1:0] xor_data,
  input  logic          ld_en,
  input  logic [DW-1:0] ld_data,
  input  logic          chk,
  input  logic          err_clr,
  output logic          err
);
  logic [DW-1:0] int_par, pkt_par;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      int_par <= '0;
      pkt_par <= '0;
      err     <= 1'b0;
    end else begin
      if (clr) int_par <= '0;
      else if (xor_en) int_par <= int_par ^ xor_data;
      if (ld_en) pkt_par <= ld_data;
      if (err_clr) err <= 1'b0;
      else if (chk) err <= int_par != pkt_par;
    end
  end
endmodule

// File: rtl/router_reg.sv
// router_reg: header latch, byte staging to the FIFO, full-state hold byte and
// parity status for the 1x3 router.
module router_reg
  import router_pkg::*;
#(
  parameter int DW = router_pkg::DW,
  parameter int AW = router_pkg::AW
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          full_state,
  input  logic          laf_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] dout,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err
);
  logic [DW-1:0] header, fsb, xor_data, ld_data;
  logic          ld_par, laf_par, xor_en, hdr_ok;
  always_comb begin
    hdr_ok   = data_in[AW-1:0] != ADDR_INVALID;
    ld_par   = ld_state && !fifo_full && !pkt_valid;
    laf_par  = laf_state && low_pkt_valid && !parity_done;
    xor_en   = lfd_state || (ld_state && pkt_valid && !fifo_full) || (laf_state && !low_pkt_valid);
    xor_data = lfd_state ? header : ld_state ? data_in : fsb;
    ld_data  = ld_state ? data_in : fsb;
  end
  // full_state carries no datapath action; dout and fsb simply hold there
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dout          <= '0;
      header        <= '0;
      fsb           <= '0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
    end else begin
      if (detect_add && pkt_valid && hdr_ok) header <= data_in;
      if (lfd_state) dout <= header;
      else if (ld_state && !fifo_full) dout <= data_in;
      else if (laf_state) dout <= fsb;
      if (ld_state && fifo_full) fsb <= data_in;
      if (rst_int_reg) low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid) low_pkt_valid <= 1'b1;
      if (detect_add) parity_done <= 1'b0;
      else if (ld_par || laf_par) parity_done <= 1'b1;
    end
  end
  router_parity_acc #(.DW(DW)) u_par (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (detect_add),
    .xor_en   (xor_en),
    .xor_data (xor_data),
    .ld_en    (ld_par || laf_par),
    .ld_data  (ld_data),
    .chk      (rst_int_reg && parity_done),
    .err_clr  (lfd_state),
    .err      (err)
  );
endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1x3 router.
- Sits between the input byte stream and the three output FIFOs. Driven by the router FSM's decoded state flags (detect_add, lfd_state, ld_state, full_state, laf_state, rst_int_reg).
- Latches the header, stages each byte onto dout for FIFO write, and holds the byte that arrives while the FIFO is full.
- Accumulates even (XOR) parity and reports parity_done, low_pkt_valid and err back to the FSM and the top level.

Parameters:
- DW, 8, byte width of data_in/dout.
- AW, 2, width of the address field in header bits [AW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source packet-valid; falls on the cycle carrying the parity byte.
- data_in  in  DW  source byte. Header is [7:2]=payload length, [1:0]=destination address.
- fifo_full  in  1  full flag of the currently addressed FIFO.
- detect_add  in  1  FSM in DECODE_ADDR.
- lfd_state  in  1  FSM in LOAD_FIRST_DATA.
- ld_state  in  1  FSM in LOAD_DATA.
- full_state  in  1  FSM in FIFO_FULL_STATE.
- laf_state  in  1  FSM in LOAD_AFTER_FULL.
- rst_int_reg  in  1  FSM in CHECK_PARITY_ERROR.
- dout  out  DW  byte presented to the FIFO write port. The FSM's we_reg qualifies it one cycle later.
- parity_done  out  1  packet parity byte has been staged.
- low_pkt_valid  out  1  pkt_valid fell while the FIFO was possibly full; parity byte is pending.
- err  out  1  received parity differs from computed parity.

Behaviour:
- Reset: all registers clear on the clk edge when rstn=0. This covers dout, header, fsb (full-state byte), int_par, pkt_par, parity_done, low_pkt_valid and err, all to 0. Reset overrides everything, including mid-packet.
- State flags are one-hot. Behaviour with more than one flag set is don't-care.
- Header: when detect_add && pkt_valid && data_in[1:0]!=2'b11, header<=data_in. Otherwise hold.
- dout, in priority order:
  - lfd_state: dout<=header.
  - ld_state && !fifo_full: dout<=data_in.
  - laf_state: dout<=fsb.
  - otherwise hold. This includes detect_add, full_state and ld_state&&fifo_full.
- fsb: when ld_state && fifo_full, fsb<=data_in. Otherwise hold.
- int_par:
  - detect_add: int_par<=0.
  - lfd_state: int_par<=int_par^header.
  - ld_state && pkt_valid && !fifo_full: int_par^=data_in.
  - laf_state && !low_pkt_valid: int_par^=fsb.
  - otherwise hold.
- pkt_par:
  - ld_state && !pkt_valid && !fifo_full: pkt_par<=data_in.
  - laf_state && low_pkt_valid && !parity_done: pkt_par<=fsb.
  - otherwise hold.
- low_pkt_valid:
  - rst_int_reg clears it (priority).
  - ld_state && !pkt_valid sets it.
  - otherwise hold.
- parity_done:
  - detect_add clears it.
  - (ld_state && !fifo_full && !pkt_valid) or (laf_state && low_pkt_valid && !parity_done) sets it.
  - otherwise hold.
- err:
  - lfd_state clears it (next packet start).
  - rst_int_reg && parity_done: err<=(int_par!=pkt_par).
  - otherwise hold. err stays visible through the following DECODE_ADDR/WAIT_TILL_EMPTY.
- Latencies:
  - data_in to dout: 1 cycle.
  - Parity byte to parity_done: 1 cycle.
  - parity_done to err valid: 1 cycle (after CHECK_PARITY_ERROR).
- Boundary cases:
  - Parity byte arrives with fifo_full=1: it is stored in fsb and released via laf_state. parity_done rises in LOAD_AFTER_FULL.
  - Header with addr 2'b11 is ignored (header holds).
  - Soft reset of the FSM returns it to DECODE_ADDR; detect_add clears int_par and parity_done.

Decomposition:
- Package router_pkg: DW, AW, ADDR_INVALID=2'b11, and header field slice constants (LEN_MSB=7, LEN_LSB=2).
- One natural sub-module: router_parity_acc. It holds int_par/pkt_par, takes clear/xor-enable/load-enable strobes, and compares the two for err. The remaining byte-staging logic stays in router_reg.

Test Plan:
- Normal packet: header 8'h0D (len 3, addr 1) in DECODE_ADDR, payload 8'h11, 8'h22, 8'h33, parity 8'h0D, fifo_full=0.
  - dout sequence is 0D, 11, 22, 33, 0D.
  - parity_done=1 the cycle after the parity byte; err=0 after CHECK_PARITY_ERROR.
- Bad parity: same packet with parity byte 8'h0E -> err=1 one cycle after rst_int_reg; err clears on the next lfd_state.
- FIFO full mid-payload: fifo_full=1 during ld_state on byte 8'h22.
  - fsb=22 and dout holds 11 through full_state.
  - laf_state gives dout=22; int_par is still correct and err=0.
- FIFO full on parity byte: fifo_full=1 as pkt_valid falls with parity 8'h0D.
  - low_pkt_valid=1 and parity_done stays 0 until laf_state; then parity_done=1, pkt_par=0D, err=0.
  - low_pkt_valid clears on rst_int_reg.
- Invalid address: header 8'h0F (addr 3) with detect_add -> header register unchanged; dout unchanged.
- Reset mid-packet: rstn=0 during ld_state -> next edge dout=0, parity_done=0, low_pkt_valid=0, err=0.
